// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR random-word generators:
//   - lfsr_taps      : Fibonacci feedback tap mask for each supported length
//   - lfsr_len_legal : true for the supported register lengths
//   - perm_index     : source bit of output bit k under a stride permutation
//   - gcd_u          : greatest common divisor, used for parameter checks
// ---------------------------------------------------------------------------
package lfsr_pkg;

    localparam int unsigned LFSR_MAX_LEN = 32;

    // Supported register lengths; each has a maximal-length tap set below.
    function automatic logic lfsr_len_legal(input int unsigned len);
        case (len)
            8, 16, 24, 32: return 1'b1;
            default:       return 1'b0;
        endcase
    endfunction

    // Tap masks as 0-indexed bit positions. The polynomials are usually
    // quoted 1-indexed: 8 (8,6,5,4), 16 (16,15,13,4), 24 (24,23,22,17),
    // 32 (32,22,2,1).
    function automatic logic [LFSR_MAX_LEN-1:0] lfsr_taps(input int unsigned len);
        case (len)
            8:       return 32'h0000_00B8;  // bits 7,5,4,3
            16:      return 32'h0000_D008;  // bits 15,14,12,3
            24:      return 32'h00E1_0000;  // bits 23,22,21,16
            32:      return 32'h8020_0003;  // bits 31,21,1,0
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Output bit k is taken from state bit (k*stride) mod len.
    function automatic int unsigned perm_index(input int unsigned k,
                                               input int unsigned stride,
                                               input int unsigned len);
        return (k * stride) % len;
    endfunction

    function automatic int unsigned gcd_u(input int unsigned a, input int unsigned b);
        int unsigned x;
        int unsigned y;
        int unsigned t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

endpackage

// File: rtl/lfsr_multistep.sv
// ---------------------------------------------------------------------------
// lfsr_multistep
// Purely combinational: applies STEPS single-bit Fibonacci LFSR shifts.
// Each shift is next = {s[REG_LEN-2:0], ^(s & tap_mask)}.
// Ports:
//   state_in  [REG_LEN] : current register state
//   tap_mask  [REG_LEN] : feedback tap mask
//   state_out [REG_LEN] : state after STEPS shifts
// ---------------------------------------------------------------------------
module lfsr_multistep #(
    parameter int unsigned REG_LEN = 16,
    parameter int unsigned STEPS   = 1
) (
    input  logic [REG_LEN-1:0] state_in,
    input  logic [REG_LEN-1:0] tap_mask,
    output logic [REG_LEN-1:0] state_out
);

    // One stage per shift; each stage owns its signals so the chain has no
    // self-referencing vector.
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
        logic [REG_LEN-1:0] cur;
        logic [REG_LEN-1:0] nxt;
        if (gi == 0) begin : g_first
            assign cur = state_in;
        end else begin : g_rest
            assign cur = g_step[gi-1].nxt;
        end
        assign nxt = {cur[REG_LEN-2:0], ^(cur & tap_mask)};
    end

    assign state_out = g_step[STEPS-1].nxt;

endmodule

// File: rtl/lfsr_prng_stream.sv
// ---------------------------------------------------------------------------
// lfsr_prng_stream
// Fibonacci LFSR random-word source with a one-entry valid/ready buffer.
// Each update advances the register STEPS positions; the output word is a
// stride permutation of the new state. Supports runtime seeding, and a zero
// seed is replaced by 1 with a one-cycle lockup_err pulse.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   seed_load  : load seed_in this cycle (discards any buffered word)
//   seed_in    : new seed, REG_LEN bits
//   out_ready  : consumer accepts out_data
//   out_valid  : out_data holds a fresh word
//   out_data   : random word, OUT_W bits
//   lockup_err : one-cycle pulse after a zero seed was replaced
// ---------------------------------------------------------------------------
module lfsr_prng_stream
    import lfsr_pkg::*;
#(
    parameter int unsigned REG_LEN = 16,
    parameter int unsigned STEPS   = 1,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned STRIDE  = 1,
    parameter logic [31:0] SEED    = 32'd1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               seed_load,
    input  logic [REG_LEN-1:0] seed_in,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [OUT_W-1:0]   out_data,
    output logic               lockup_err
);

    localparam logic [LFSR_MAX_LEN-1:0] TAP_MASK_FULL = lfsr_taps(REG_LEN);
    localparam logic [REG_LEN-1:0]      TAP_MASK      = TAP_MASK_FULL[REG_LEN-1:0];
    localparam logic [REG_LEN-1:0]      SEED_INIT     = SEED[REG_LEN-1:0];
    localparam logic [REG_LEN-1:0]      ONE_STATE     = {{(REG_LEN-1){1'b0}}, 1'b1};
    localparam bit                      LEN_OK        = lfsr_len_legal(REG_LEN);

    // Parameter sanity checks at elaboration.
    if (!LEN_OK) begin : g_bad_len
        $error("lfsr_prng_stream: REG_LEN must be 8, 16, 24 or 32");
    end
    if (STEPS < 1 || STEPS > REG_LEN) begin : g_bad_steps
        $error("lfsr_prng_stream: STEPS must be in 1..REG_LEN");
    end
    if (OUT_W < 1 || OUT_W > REG_LEN) begin : g_bad_out_w
        $error("lfsr_prng_stream: OUT_W must be in 1..REG_LEN");
    end
    if ((STRIDE % 2) == 0 || gcd_u(STRIDE, REG_LEN) != 1) begin : g_bad_stride
        $error("lfsr_prng_stream: STRIDE must be odd and coprime with REG_LEN");
    end
    if (SEED_INIT == '0) begin : g_bad_seed
        $error("lfsr_prng_stream: SEED must be nonzero");
    end

    logic [REG_LEN-1:0] state_q;
    logic [REG_LEN-1:0] state_d;
    logic               out_valid_q;
    logic               out_valid_d;
    logic [OUT_W-1:0]   out_data_q;
    logic [OUT_W-1:0]   out_data_d;
    logic               lockup_err_q;
    logic               lockup_err_d;

    logic [REG_LEN-1:0] step_state;
    logic [OUT_W-1:0]   perm_word;
    logic               adv;

    lfsr_multistep #(
        .REG_LEN (REG_LEN),
        .STEPS   (STEPS)
    ) u_multistep (
        .state_in  (state_q),
        .tap_mask  (TAP_MASK),
        .state_out (step_state)
    );

    // Pure wiring: each output bit picks a fixed bit of the advanced state.
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_perm
        localparam int unsigned SRC = perm_index(gi, STRIDE, REG_LEN);
        assign perm_word[gi] = step_state[SRC];
    end

    // The buffer refills when empty or when its word is being taken.
    assign adv = !seed_load && (!out_valid_q || out_ready);

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        lockup_err_d = 1'b0;
        if (seed_load) begin
            // A reload invalidates the buffered word so no word from the old
            // sequence escapes after the reseed.
            out_valid_d = 1'b0;
            if (seed_in == '0) begin
                state_d      = ONE_STATE;
                lockup_err_d = 1'b1;
            end else begin
                state_d = seed_in;
            end
        end else if (adv) begin
            state_d     = step_state;
            out_data_d  = perm_word;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SEED_INIT;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            lockup_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            lockup_err_q <= lockup_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign lockup_err = lockup_err_q;

endmodule
